sipo_rx_ctrl: RTL

//  Frame-level receive controller that sequences the 8-bit SIPO shifter.

---
 rtl/sipo_rx_pkg.sv | 19 +
 rtl/sipo_rx_ctrl_bit_timer.sv | 33 +++
 rtl/sipo_rx_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the SIPO receive controller.
package sipo_rx_pkg;

  // Width of the external SIPO shifter; the controller's DATA_BITS defaults to it.
  localparam int SIPO_WIDTH = 8;

  // Seed of the running parity XOR; 0 selects even parity.
  localparam logic PARITY_EVEN = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sipo_rx_ctrl_bit_timer.sv
// Loadable down-counter. Expires for one cycle when it reaches zero.
// The counter stops there unless it is reloaded.
module bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;

  // Count down while armed. A load restarts the count, even on the expiry cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) r_active <= 1'b0;
      else               r_count  <= r_count - 1'b1;
    end
  end

  assign o_expire = r_active && (r_count == '0);

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame-level receive controller that drives an external 8-bit SIPO shifter.
// It samples each serial bit at mid-period and checks the parity and stop bits.
// Good bytes are delivered on a valid/ready port; bad frames raise error pulses.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = SIPO_WIDTH,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  output logic                 sipo_serial_in,
  output logic                 sipo_in_valid,
  input  logic [DATA_BITS-1:0] sipo_data,
  input  logic                 sipo_out_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  rx_state_t r_state, w_state_next;

  logic r_sync1, r_sync2, r_rx_prev;
  logic w_rx_s, w_fall, w_expire;
  logic w_timer_load, w_frame_start, w_strobe, w_sample_par;
  logic w_frame_err, w_parity_err, w_deliver;
  logic [TW-1:0] w_timer_val;

  logic [IW-1:0]        r_bit_idx;
  logic                 r_xor, r_parity_bad, r_seen_valid;
  logic [DATA_BITS-1:0] r_pending, r_byte_data;
  logic                 r_byte_valid, r_sipo_in_valid, r_sipo_serial_in;
  logic                 r_parity_err, r_frame_err, r_overrun_err;

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_prev && !r_sync2;

  // Two-flop synchroniser plus the edge-detect history. All three reset to the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_line;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  bit_timer #(.WIDTH(TW)) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_expire   (w_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and the one-cycle decode strobes used by the datapath.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch forms.
    w_state_next  = r_state;
    w_timer_load  = 1'b0;
    w_timer_val   = FULL_LOAD;
    w_frame_start = 1'b0;
    w_strobe      = 1'b0;
    w_sample_par  = 1'b0;
    w_frame_err   = 1'b0;
    w_parity_err  = 1'b0;
    w_deliver     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_fall) begin
        w_state_next = ST_START;
        w_timer_load = 1'b1;
        w_timer_val  = HALF_LOAD;
      end
      ST_START: if (w_expire) begin
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next  = ST_DATA;
          w_timer_load  = 1'b1;
          w_frame_start = 1'b1;
        end
      end
      ST_DATA: if (w_expire) begin
        w_strobe     = 1'b1;
        w_timer_load = 1'b1;
        if (r_bit_idx == LAST_IDX) w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (w_expire) begin
        w_sample_par = 1'b1;
        w_timer_load = 1'b1;
        w_state_next = ST_STOP;
      end
      ST_STOP: if (w_expire) begin
        if (!w_rx_s || !r_seen_valid) begin
          w_frame_err  = 1'b1;
          w_state_next = ST_WAIT_IDLE;
        end else if (r_parity_bad) begin
          w_parity_err = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_deliver    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: if (w_rx_s) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: shift strobes, parity tracking, the pending byte, output handshake and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_idx        <= '0;
      r_xor            <= PARITY_EVEN;
      r_parity_bad     <= 1'b0;
      r_seen_valid     <= 1'b0;
      r_pending        <= '0;
      r_byte_data      <= '0;
      r_byte_valid     <= 1'b0;
      r_sipo_in_valid  <= 1'b0;
      r_sipo_serial_in <= 1'b0;
      r_parity_err     <= 1'b0;
      r_frame_err      <= 1'b0;
      r_overrun_err    <= 1'b0;
    end else begin
      r_sipo_in_valid <= w_strobe;
      r_frame_err     <= w_frame_err;
      r_parity_err    <= w_parity_err;
      r_overrun_err   <= w_deliver && r_byte_valid && !byte_ready;

      if (w_frame_start) begin
        r_bit_idx    <= '0;
        r_xor        <= PARITY_EVEN;
        r_parity_bad <= 1'b0;
        r_seen_valid <= 1'b0;
      end
      if (w_strobe) begin
        r_sipo_serial_in <= w_rx_s;
        r_bit_idx        <= r_bit_idx + 1'b1;
        r_xor            <= r_xor ^ w_rx_s;
      end
      if (w_sample_par) r_parity_bad <= r_xor ^ w_rx_s;
      if (sipo_out_valid) begin
        r_pending    <= sipo_data;
        r_seen_valid <= 1'b1;
      end

      // Accept first. A delivery in the same cycle can then reuse the freed slot.
      if (r_byte_valid && byte_ready) r_byte_valid <= 1'b0;
      if (w_deliver && (!r_byte_valid || byte_ready)) begin
        r_byte_data  <= r_pending;
        r_byte_valid <= 1'b1;
      end
    end
  end

  assign sipo_serial_in = r_sipo_serial_in;
  assign sipo_in_valid  = r_sipo_in_valid;
  assign byte_data      = r_byte_data;
  assign byte_valid     = r_byte_valid;
  assign parity_err     = r_parity_err;
  assign frame_err      = r_frame_err;
  assign overrun_err    = r_overrun_err;
  assign busy           = (r_state != ST_IDLE);

endmodule
